// File: rtl/decode_stage.sv
// RV32I-subset decode stage: register file with write-through bypass, main/ALU
// decoders and immediate extender. All decode outputs are combinational from InstrD.
module decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           InstrD,
  input  logic                  RegWriteW,
  input  logic [4:0]            RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] ImmExtD,
  output logic [4:0]            Rs1D,
  output logic [4:0]            Rs2D,
  output logic [4:0]            RdD,
  output logic                  RegWriteD,
  output logic                  MemWriteD,
  output logic                  jumpD,
  output logic                  branchD,
  output logic                  ALUSrcD,
  output logic [1:0]            ResultSrcD,
  output logic [2:0]            ALUControlD,
  output logic                  IllegalD
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {IMM_Z, IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    imm_src_e   imm_src;
  } ctrl_t;

  // ---------------- register file ----------------
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic                                 wr_en;

  assign wr_en = RegWriteW && (RdW != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[RdW] = ResultW;
  end

  // reset wins over a write presented in the same cycle
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];
  assign RdD  = InstrD[11:7];

  // write-through bypass lets decode see the writeback value in the same cycle
  assign RD1 = (Rs1D == 5'd0)              ? '0      :
               (wr_en && (RdW == Rs1D))    ? ResultW : regs_q[Rs1D];
  assign RD2 = (Rs2D == 5'd0)              ? '0      :
               (wr_en && (RdW == Rs2D))    ? ResultW : regs_q[Rs2D];

  // ---------------- main decoder ----------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  ctrl_t      ctrl;
  logic       op_ok;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];

  always_comb begin
    ctrl  = '0;
    op_ok = 1'b1;
    case (opcode)
      OP_LW: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
        ctrl.result_src = 2'b01; ctrl.imm_src = IMM_I;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.imm_src = IMM_S;
      end
      OP_R: begin
        ctrl.reg_write = 1'b1; ctrl.alu_op = 2'b10; ctrl.imm_src = IMM_Z;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1; ctrl.alu_op = 2'b01; ctrl.imm_src = IMM_B;
      end
      OP_IALU: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
        ctrl.alu_op = 2'b10; ctrl.imm_src = IMM_I;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1;
        ctrl.result_src = 2'b10; ctrl.imm_src = IMM_J;
      end
      default: op_ok = 1'b0;
    endcase
  end

  // ---------------- ALU decoder ----------------
  logic [2:0] alu_ctrl;
  logic       f3_ok;

  always_comb begin
    alu_ctrl = ALU_ADD;
    f3_ok    = 1'b1;
    case (ctrl.alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl = (opcode[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: f3_ok    = 1'b0;
        endcase
      end
    endcase
  end

  // ---------------- immediate extender ----------------
  logic [DATA_WIDTH-1:0] imm_ext;

  always_comb begin
    imm_ext = '0;
    case (ctrl.imm_src)
      IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // illegal instructions become a bubble: every control output forced low
  assign IllegalD    = !(op_ok && f3_ok);
  assign RegWriteD   = ctrl.reg_write  & ~IllegalD;
  assign MemWriteD   = ctrl.mem_write  & ~IllegalD;
  assign jumpD       = ctrl.jump       & ~IllegalD;
  assign branchD     = ctrl.branch     & ~IllegalD;
  assign ALUSrcD     = ctrl.alu_src    & ~IllegalD;
  assign ResultSrcD  = IllegalD ? 2'b00 : ctrl.result_src;
  assign ALUControlD = IllegalD ? 3'b000 : alu_ctrl;
  assign ImmExtD     = IllegalD ? '0 : imm_ext;

endmodule

// File: tb/tb_decode_stage.sv
// Random + directed bench for decode_stage against a table-driven RV32I-subset
// decode model and an array register-file model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [31:0] RD1, RD2, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, MemWriteD, jumpD, branchD, ALUSrcD, IllegalD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] m_rf [32];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .RegWriteW(RegWriteW),
    .RdW(RdW), .ResultW(ResultW), .RD1(RD1), .RD2(RD2), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .jumpD(jumpD), .branchD(branchD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .IllegalD(IllegalD)
  );

  typedef struct packed {
    logic        rw, mw, jmp, br, asrc;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
    logic        ill;
    logic [31:0] imm;
  } dec_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h instr=%h", tag, got, exp, InstrD);
    end
  endtask

  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    int   aluop;
    bit   legal;
    d = '0; aluop = 0; legal = 1;
    case (i[6:0])
      7'b0000011: begin d.rw = 1; d.asrc = 1; d.rsrc = 2'b01;
                        d.imm = {{20{i[31]}}, i[31:20]}; end
      7'b0100011: begin d.mw = 1; d.asrc = 1;
                        d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
      7'b0110011: begin d.rw = 1; aluop = 2; end
      7'b1100011: begin d.br = 1; aluop = 1;
                        d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
      7'b0010011: begin d.rw = 1; d.asrc = 1; aluop = 2;
                        d.imm = {{20{i[31]}}, i[31:20]}; end
      7'b1101111: begin d.rw = 1; d.jmp = 1; d.rsrc = 2'b10;
                        d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
      default: legal = 0;
    endcase
    if (aluop == 1) d.aluc = 3'b001;
    else if (aluop == 2) begin
      case (i[14:12])
        3'b000:  d.aluc = (i[5] && i[30]) ? 3'b001 : 3'b000;
        3'b010:  d.aluc = 3'b101;
        3'b110:  d.aluc = 3'b011;
        3'b111:  d.aluc = 3'b010;
        default: legal = 0;
      endcase
    end
    if (!legal) begin d = '0; d.ill = 1; end
    return d;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (RegWriteW && RdW != 0 && RdW == idx) return ResultW;
    return m_rf[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) for (int k = 0; k < 32; k++) m_rf[k] = 32'h0;
    else if (RegWriteW && RdW != 0) m_rf[RdW] = ResultW;
    @(negedge clk);
  endtask

  task automatic check_all();
    dec_t e;
    e = ref_decode(InstrD);
    chk("rd1", RD1, ref_read(InstrD[19:15]));
    chk("rd2", RD2, ref_read(InstrD[24:20]));
    chk("rs1", Rs1D, InstrD[19:15]);
    chk("rs2", Rs2D, InstrD[24:20]);
    chk("rd",  RdD,  InstrD[11:7]);
    chk("regwrite", RegWriteD, e.rw);
    chk("memwrite", MemWriteD, e.mw);
    chk("jump", jumpD, e.jmp);
    chk("branch", branchD, e.br);
    chk("alusrc", ALUSrcD, e.asrc);
    chk("resultsrc", ResultSrcD, e.rsrc);
    chk("aluctl", ALUControlD, e.aluc);
    chk("illegal", IllegalD, e.ill);
    if (!e.ill) chk("imm", ImmExtD, e.imm);
  endtask

  task automatic apply(input logic [31:0] instr);
    InstrD = instr;
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  ops [6];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b1100011; ops[4] = 7'b0010011; ops[5] = 7'b1101111;
    reset = 1'b1; InstrD = '0; RegWriteW = 0; RdW = '0; ResultW = '0;
    for (int k = 0; k < 32; k++) m_rf[k] = 32'hX;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;

    // all registers read zero after reset
    for (int i = 1; i < 32; i++) begin
      logic [4:0] a, b;
      a = 5'(i); b = 5'(32 - i);
      InstrD = {7'b0, b, a, 3'b000, 5'd3, 7'b0110011};
      #1;
      chk("rst_rd1", RD1, 32'h0);
      chk("rst_rd2", RD2, 32'h0);
    end

    // x0 is hardwired
    RegWriteW = 1; RdW = 5'd0; ResultW = 32'hDEADBEEF;
    InstrD = {7'b0, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0110011};
    #1 chk("x0_byp", RD1, 32'h0);
    tick();
    RegWriteW = 0;
    #1 chk("x0_stored", RD1, 32'h0);

    // bypass then storage
    RegWriteW = 1; RdW = 5'd5; ResultW = 32'h12345678;
    InstrD = {7'b0, 5'd0, 5'd5, 3'b000, 5'd1, 7'b0110011};
    #1 chk("byp_rd1", RD1, 32'h12345678);
    tick();
    RegWriteW = 0;
    #1 chk("stored_rd1", RD1, 32'h12345678);

    // directed decodes with hand-derived expectations
    apply(32'h00500093);
    chk("addi_rw", RegWriteD, 1); chk("addi_asrc", ALUSrcD, 1);
    chk("addi_alu", ALUControlD, 3'b000); chk("addi_imm", ImmExtD, 32'd5);
    chk("addi_rd", RdD, 5'd1);
    apply(32'h402081B3);
    chk("sub_alu", ALUControlD, 3'b001); chk("sub_asrc", ALUSrcD, 0);
    apply(32'hFE20AE23);
    chk("sw_mw", MemWriteD, 1); chk("sw_rw", RegWriteD, 0);
    chk("sw_imm", ImmExtD, 32'hFFFFFFFC);
    apply(32'h0080A103);
    chk("lw_rsrc", ResultSrcD, 2'b01); chk("lw_imm", ImmExtD, 32'd8);
    apply(32'hFE208CE3);
    chk("beq_br", branchD, 1); chk("beq_alu", ALUControlD, 3'b001);
    chk("beq_imm", ImmExtD, 32'hFFFFFFF8);
    apply(32'h010000EF);
    chk("jal_j", jumpD, 1); chk("jal_rsrc", ResultSrcD, 2'b10);
    chk("jal_imm", ImmExtD, 32'h10);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] instr;
      int k;
      r = $urandom();
      k = $urandom_range(0, 7);
      instr = {r[31:7], (k < 6) ? ops[k] : r[6:0]};
      if ($urandom_range(0, 1) == 1) begin
        instr[19:15] = 5'($urandom_range(0, 7));
        instr[24:20] = 5'($urandom_range(0, 7));
      end
      RegWriteW = 1'($urandom_range(0, 1));
      RdW       = 5'($urandom_range(0, 7));
      ResultW   = $urandom();
      apply(instr);
      tick();
    end

    // reset beats a simultaneous write
    RegWriteW = 1; RdW = 5'd7; ResultW = 32'hAA;
    InstrD = {7'b0, 5'd0, 5'd7, 3'b000, 5'd1, 7'b0110011};
    tick();
    RegWriteW = 0;
    #1 chk("x7_aa", RD1, 32'hAA);
    reset = 1; RegWriteW = 1; RdW = 5'd7; ResultW = 32'hBB;
    tick();
    reset = 0; RegWriteW = 0;
    #1 chk("x7_rst", RD1, 32'h0);

    // flushed fetch register decodes to a bubble
    apply(32'h00000000);
    chk("nop_ill", IllegalD, 1);
    chk("nop_ctl", {RegWriteD, MemWriteD, jumpD, branchD, ALUSrcD, ResultSrcD, ALUControlD}, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
